// File: rtl/load_event_pkg.sv
// Shared types and sizing helpers for the load-button event controller.
package load_event_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      HOLD_WAIT = 2'd1,
      REPEAT    = 2'd2
   } state_e;

   // Timer width that can hold both terminal counts without wrapping.
   function automatic int unsigned timer_w(input int unsigned delay, input int unsigned period);
      int unsigned m;
      m = (delay > period) ? delay : period;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/load_event_ctrl_if.sv
// Captured-word output handshake between the event controller and its consumer.
interface load_event_ctrl_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/load_repeat_timer.sv
// Hold/repeat cycle counter with clear, enable and terminal-count compare against a selectable limit.
module load_repeat_timer #(
   parameter int unsigned TW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic [TW-1:0] limit,
   output logic          tc_c
);
   logic [TW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + TW'(1);
      end
   end

   assign tc_c = (cnt == limit);
endmodule

// File: rtl/load_event_ctrl.sv
// Turns the debounced load level into capture events (press + hold-to-repeat) and
// offers each captured switch word on a valid/ready output register.
module load_event_ctrl
   import load_event_pkg::*;
#(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned REPEAT_EN     = 1,
   parameter int unsigned REPEAT_DELAY  = 25_000_000,
   parameter int unsigned REPEAT_PERIOD = 5_000_000,
   parameter int unsigned CNT_W         = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                z_n,
   input  logic [DATA_W-1:0]   din,
   input  logic                ovr_clr,
   load_event_ctrl_if.master   out,
   output logic                repeat_active,
   output logic [CNT_W-1:0]    evt_count,
   output logic                overrun
);
   localparam int unsigned TW        = timer_w(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [TW-1:0] DELAY_TC  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_TC = TW'(REPEAT_PERIOD - 1);
   localparam bit RPT = (REPEAT_EN != 0);

   state_e            state;
   state_e            state_nxt;
   logic              z_prev;
   logic              press_edge_c;
   logic              tc_c;
   logic              evt_c;
   logic              drop_c;
   logic              tmr_clr_c;
   logic              tmr_en_c;
   logic [TW-1:0]     tmr_limit_c;
   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;

   // z_prev resets to "pressed" so a press held through reset cannot fire.
   assign press_edge_c = !z_n && z_prev;
   assign tmr_limit_c  = (state == REPEAT) ? PERIOD_TC : DELAY_TC;
   assign drop_c       = evt_c && out_valid_q && !out.out_ready;

   load_repeat_timer #(.TW(TW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (tmr_clr_c),
      .en    (tmr_en_c),
      .limit (tmr_limit_c),
      .tc_c  (tc_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (press_edge_c) state_nxt = HOLD_WAIT;
         HOLD_WAIT: begin
            if (z_n)              state_nxt = IDLE;
            else if (RPT && tc_c) state_nxt = REPEAT;
         end
         REPEAT:    if (z_n) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Release beats a same-cycle expiry: the timer only runs while still held.
   always_comb begin
      evt_c     = 1'b0;
      tmr_clr_c = 1'b1;
      tmr_en_c  = 1'b0;
      case (state)
         IDLE: evt_c = press_edge_c;
         HOLD_WAIT, REPEAT: begin
            if (!z_n && RPT) begin
               if (tc_c) begin
                  evt_c = 1'b1;
               end else begin
                  tmr_clr_c = 1'b0;
                  tmr_en_c  = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         z_prev        <= 1'b0;
         repeat_active <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         evt_count     <= '0;
         overrun       <= 1'b0;
      end else begin
         z_prev        <= z_n;
         repeat_active <= (state_nxt == REPEAT);
         if (evt_c && !drop_c) begin
            out_data_q  <= din;
            out_valid_q <= 1'b1;
            evt_count   <= evt_count + CNT_W'(1);
         end else if (out_valid_q && out.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (drop_c) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign out.out_valid = out_valid_q;
   assign out.out_data  = out_data_q;
endmodule

// File: doc/load_event_ctrl.md
# load_event_ctrl

Downstream stage of the debounced load-button delay block. Consumes its active-low "load held" level, turns each press into a single data-capture event, and adds hold-to-repeat auto-events. Each event latches the switch word into an output register offered on a valid/ready handshake. Sits between the button-conditioning front end and the counter/display datapath that consumes loaded values.

## Interface
- DATA_W, 8: width of captured switch word.
- REPEAT_EN, 1: 1 enables hold-to-repeat; 0 gives one event per press.
- REPEAT_DELAY, 25_000_000: cycles from first event to first repeat event; must be ≥2.
- REPEAT_PERIOD, 5_000_000: cycles between repeat events; must be ≥2.
- CNT_W, 8: width of event counter.

- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- z_n  in  1  debounced load level from the delay stage; 0 = pressed and qualified, 1 = released.
- din  in  DATA_W  switch word; sampled only on an event.
- ovr_clr  in  1  synchronous clear of overrun.
- out_valid  out  1  out_data holds an unconsumed event.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  DATA_W  captured din.
- repeat_active  out  1  high while in REPEAT state.
- evt_count  out  CNT_W  number of events loaded into out_data, modulo 2^CNT_W.
- overrun  out  1  sticky: an event was dropped because out_valid was held.

## Operation
- Reset values: out_valid 0, out_data 0, repeat_active 0, evt_count 0, overrun 0, state IDLE, timer 0, z_prev 0.
- z_prev resets to 0 (treated as pressed): a press held through reset must be released before it can fire.
- Event sources: press edge (z_n==0 && z_prev==1) in IDLE; timer expiry in HOLD_WAIT or REPEAT.
- States:
  - IDLE: press edge → emit event, timer←0, go HOLD_WAIT.
  - HOLD_WAIT: timer increments each cycle; at timer==REPEAT_DELAY-1 with REPEAT_EN=1 → emit event, timer←0, go REPEAT. With REPEAT_EN=0, timer is held at 0 and the state is held until release.
  - REPEAT: timer increments; at timer==REPEAT_PERIOD-1 → emit event, timer←0.
  - In any state, z_n==1 → go IDLE, timer←0. Release takes priority over a same-cycle expiry; no event is emitted.
- Event handling, evaluated in one cycle:
  - If out_valid==0, or out_valid && out_ready: out_data←din, out_valid←1, evt_count+1 (wraps).
  - Else the event is dropped: out_data is unchanged, evt_count is unchanged, overrun←1.
- Handshake: out_valid clears on accept with no simultaneous event. out_data is stable while out_valid && !out_ready.
- overrun is set by drops and cleared only by ovr_clr or reset. A drop in the same cycle as ovr_clr sets it (set wins).
- Timer width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)); it must not wrap.

## Timing
- Press edge sampled at edge t: out_valid=1 and out_data=din(t) after edge t. Latency 1 cycle, registered outputs only.
- First repeat event: REPEAT_DELAY cycles after the first event. Subsequent repeats every REPEAT_PERIOD cycles.
- repeat_active rises in the same cycle as the first repeat event and falls the cycle after release is sampled.
- Reset mid-hold: the state machine returns to IDLE and no event fires until z_n has gone 1 then 0.
- Release followed by a press with one cycle at z_n=1: the press is a new edge and fires a new event.

## Structure
- Package load_event_pkg: state enum {IDLE, HOLD_WAIT, REPEAT}; timer-width helper function.
- Sub-module load_repeat_timer: counter with clear, enable and a terminal-count compare against a runtime-selected limit (REPEAT_DELAY-1 or REPEAT_PERIOD-1). The FSM and output register stay in the top module.

## Test plan
Directed tests use DATA_W=8, REPEAT_DELAY=10, REPEAT_PERIOD=4, out_ready=1 unless stated.

- Single press: din=0x5A, z_n 1→0 held 5 cycles then released → one out_valid pulse with out_data=0x5A, evt_count=1, repeat_active stays 0.
- Hold repeat: z_n low for 30 cycles → events at cycles 0, 10, 14, 18, 22, 26 relative to the first event (6 total), evt_count=6, repeat_active high from cycle 10 until release.
- Backpressure: out_ready=0 during a hold producing 3 events → out_data keeps the first din, overrun=1, evt_count=1. Then ovr_clr → overrun=0.
- Simultaneous accept + event: out_valid=1, out_ready=1 in the same cycle as a repeat expiry → new din loaded, out_valid stays 1, overrun=0.
- Reset while held: assert reset during REPEAT with z_n kept 0 → all outputs return to reset values and no event until z_n pulses 1 then 0.
- REPEAT_EN=0: hold 50 cycles → exactly one event, evt_count=1.
